mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 8..64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 start  in  1  request a new operation; accepted only in IDLE or DONE.
REQ-005 op_signed  in  1  1 = two's-complement operands (SMULL/MUL), 0 = unsigned (UMULL).
REQ-006 op_long  in  1  1 = 2*WIDTH result on result_hi:result_lo; 0 = low WIDTH bits only, result_hi forced 0.
REQ-007 a, b  in  WIDTH  multiplicand, multiplier; sampled with start.
REQ-008 acc_hi, acc_lo  in  WIDTH  accumulate addend; present only with MUL_ACCUM_EN.
REQ-009 acc_en  in  1  add acc to product; present only with MUL_ACCUM_EN.
REQ-010 busy  out  1  high in CALC and FIX.
REQ-011 done  out  1  one-cycle pulse in DONE.
REQ-012 result_lo, result_hi  out  WIDTH  product; held stable from DONE until the next accepted start.
REQ-013 flag_n, flag_z  out  1  sign and zero of the delivered result (2*WIDTH bits if op_long, else result_lo).

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE.
REQ-015 IDLE/DONE + start=1 -> CALC; capture operands and mode bits; clear accumulator and bit counter.
REQ-016 IDLE + start=0 -> IDLE; DONE + start=0 -> IDLE.
REQ-017 CALC: shift-add radix-2 on operand magnitudes, one multiplier bit per cycle; exactly WIDTH cycles, counter 0..WIDTH-1, then -> FIX.
REQ-018 FIX (1 cycle): negate the 2*WIDTH product if op_signed and sign(a) XOR sign(b); then add sign/zero-extended acc if acc_en; register results and flags; -> DONE.
REQ-019 Latency: start sampled at edge 0 -> done high during the cycle after edge WIDTH+2; back-to-back start in DONE yields the next done WIDTH+3 cycles later.
REQ-020 start while busy is ignored; captured operands remain unchanged.
REQ-021 Magnitude of the most-negative operand (-2^(WIDTH-1)) is computed in WIDTH+1 bits; no overflow is permitted.
REQ-022 Accumulate sum wraps modulo 2^(2*WIDTH); no carry-out is reported.
REQ-023 Input changes on a, b, op_* outside the start cycle have no effect on the operation.

Reset
REQ-024 reset=0 at a clock edge -> IDLE, busy=0, done=0, result_hi=result_lo=0, flag_n=0, flag_z=1, counter=0; this applies also mid-CALC/FIX, and the aborted operation produces no done.
REQ-025 start asserted in the same cycle as reset=0 is discarded.

Configuration
REQ-026 Macro MUL_ACCUM_EN defined: acc_hi, acc_lo, and acc_en ports exist and the FIX add is built (MLA/UMLAL/SMLAL).
REQ-027 MUL_ACCUM_EN undefined: those ports and the adder are absent, FIX performs sign correction only, and latency is unchanged.

Structure
REQ-028 Package mul_pkg holds the state enum (IDLE, CALC, FIX, DONE) and the counter-width function clog2(WIDTH).
REQ-029 Sub-module mul_ctrl holds the FSM and bit counter and drives shift/load/fix enables; mul_unit holds the datapath registers.

Verification (WIDTH=32)
REQ-030 Unsigned short: a=7, b=6 -> done during the cycle after edge 34, result_lo=0x0000002A, result_hi=0, flag_z=0.
REQ-031 UMULL: a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flag_n=1.
REQ-032 SMULL: a=0xFFFFFFFF (-1), b=2 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFE, flag_n=1; a=b=0x80000000 -> result_hi=0x40000000, result_lo=0.
REQ-033 Zero plus stray start: a=0, b=0x1234 -> flag_z=1; a start pulse at cycle 5 with a=9 is ignored, and the result remains 0.
REQ-034 Reset mid-op: reset=0 at cycle 10 of CALC -> next cycle IDLE, all outputs at reset values, no done pulse.
REQ-035 With MUL_ACCUM_EN: UMLAL a=3, b=4, acc_hi=0, acc_lo=0xFFFFFFFF -> result_hi=1, result_lo=0x0000000B.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the sequential multiplier: controller state encoding and a
// constant-width helper used to size the bit counter.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Controller for mul_unit: IDLE/CALC/FIX/DONE sequencing, the multiplier bit
// counter, and the capture/prep/shift/fix enables for the datapath.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       o_capture,
  output logic       o_prep,
  output logic       o_shift,
  output logic       o_fix,
  output logic       o_busy,
  output logic       o_done,
  output mul_state_e o_state
);

  localparam int CW = clog2(WIDTH);

  mul_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_prep;
  logic            r_busy;
  logic            r_done;
  logic            w_idle_or_done;

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);

  // The first CALC cycle converts the captured operands to magnitudes; the
  // WIDTH shift-add cycles follow with the counter running 0..WIDTH-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_prep  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= CALC;
            r_cnt   <= '0;
            r_prep  <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        CALC: begin
          if (r_prep) begin
            r_prep <= 1'b0;
          end else if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_capture = w_idle_or_done && start;
  assign o_prep    = (r_state == CALC) && r_prep;
  assign o_shift   = (r_state == CALC) && !r_prep;
  assign o_fix     = (r_state == FIX);
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_state   = r_state;

endmodule

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier (MUL/UMULL/SMULL); defining MUL_ACCUM_EN adds
// the accumulate ports and the FIX-cycle adder (MLA/UMLAL/SMLAL).
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_long,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MUL_ACCUM_EN
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             acc_en,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z,
  output mul_state_e       o_dbg_state
);

  localparam int W2 = 2 * WIDTH;

  logic             w_capture, w_prep, w_shift, w_fix;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_signed, r_long, r_neg;
  logic [W2-1:0]    r_mcand, r_prod;
  logic [WIDTH:0]   r_mplier;
  logic [WIDTH-1:0] r_res_lo, r_res_hi;
  logic             r_flag_n, r_flag_z;
  logic [WIDTH:0]   w_sext_a, w_sext_b, w_mag_a, w_mag_b;
  logic [W2-1:0]    w_prod_fixed, w_sum;
`ifdef MUL_ACCUM_EN
  logic [W2-1:0]    r_acc;
  logic             r_acc_en;
`endif

  mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .o_capture(w_capture),
    .o_prep   (w_prep),
    .o_shift  (w_shift),
    .o_fix    (w_fix),
    .o_busy   (busy),
    .o_done   (done),
    .o_state  (o_dbg_state)
  );

  // One extra bit keeps -2^(WIDTH-1) representable as a positive magnitude.
  assign w_sext_a = {r_signed & r_a[WIDTH-1], r_a};
  assign w_sext_b = {r_signed & r_b[WIDTH-1], r_b};
  assign w_mag_a  = w_sext_a[WIDTH] ? -w_sext_a : w_sext_a;
  assign w_mag_b  = w_sext_b[WIDTH] ? -w_sext_b : w_sext_b;

  assign w_prod_fixed = r_neg ? -r_prod : r_prod;
`ifdef MUL_ACCUM_EN
  assign w_sum = w_prod_fixed + (r_acc_en ? r_acc : '0);
`else
  assign w_sum = w_prod_fixed;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_long   <= 1'b0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b1;
`ifdef MUL_ACCUM_EN
      r_acc    <= '0;
      r_acc_en <= 1'b0;
`endif
    end else begin
      if (w_capture) begin
        r_a      <= a;
        r_b      <= b;
        r_signed <= op_signed;
        r_long   <= op_long;
        r_prod   <= '0;
`ifdef MUL_ACCUM_EN
        r_acc    <= op_long ? {acc_hi, acc_lo}
                            : {{WIDTH{op_signed & acc_lo[WIDTH-1]}}, acc_lo};
        r_acc_en <= acc_en;
`endif
      end
      if (w_prep) begin
        r_mcand  <= W2'(w_mag_a);
        r_mplier <= w_mag_b;
        r_neg    <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
      end
      if (w_shift) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      // Short ops report flags on the low word only.
      if (w_fix) begin
        r_res_lo <= w_sum[WIDTH-1:0];
        r_res_hi <= r_long ? w_sum[W2-1:WIDTH] : '0;
        r_flag_n <= r_long ? w_sum[W2-1] : w_sum[WIDTH-1];
        r_flag_z <= r_long ? (w_sum == '0) : (w_sum[WIDTH-1:0] == '0);
      end
    end
  end

  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign flag_n    = r_flag_n;
  assign flag_z    = r_flag_z;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit at WIDTH=32; accumulate vector is built when
// MUL_ACCUM_EN is defined.
module tb_mul_unit;
  import mul_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op_signed = 1'b0;
  logic         op_long = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef MUL_ACCUM_EN
  logic [W-1:0] acc_hi = '0;
  logic [W-1:0] acc_lo = '0;
  logic         acc_en = 1'b0;
`endif
  logic         busy, done, flag_n, flag_z;
  logic [W-1:0] result_lo, result_hi;
  mul_state_e   o_dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mul_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_signed  (op_signed),
    .op_long    (op_long),
    .a          (a),
    .b          (b),
`ifdef MUL_ACCUM_EN
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .acc_en     (acc_en),
`endif
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation from the current cycle and waits for done; a, b and
  // op_* are scrambled after the start edge, and an optional stray start is
  // driven on CALC cycle `stray`.
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic ts, input logic tl, input int stray,
                       input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                       input logic e_n, input logic e_z);
    int n;
    exp_q.push_back(e_lo);
    exp_q.push_back(e_hi);
    a = ta; b = tb_v; op_signed = ts; op_long = tl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    op_signed = 1'($urandom_range(0, 1));
    op_long = 1'($urandom_range(0, 1));
    check({name, "_busy"}, busy, 1);
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++; #1;
      if (done) break;
      if (n == stray) begin start = 1'b1; a = 32'd9; end
      else start = 1'b0;
    end
    start = 1'b0;
    check({name, "_latency"}, n, W + 2);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_lo"}, result_lo, exp_q.pop_front());
    check({name, "_hi"}, result_hi, exp_q.pop_front());
    check({name, "_n"}, flag_n, e_n);
    check({name, "_z"}, flag_z, e_z);
  endtask

  initial begin
    int done_seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_state", o_dbg_state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_n", flag_n, 0);
    check("rst_z", flag_z, 1);

    do_op("umul_7x6", 32'd7, 32'd6, 0, 0, 0, 32'h0, 32'h2A, 0, 0);
    do_op("umull_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 32'hFFFFFFFE, 32'h1, 1, 0);

    // done is a single pulse and the result holds once back in IDLE
    @(posedge clk); #1;
    check("pulse_done", done, 0);
    check("pulse_state", o_dbg_state, IDLE);
    repeat (3) @(posedge clk); #1;
    check("hold_lo", result_lo, 32'h1);
    check("hold_hi", result_hi, 32'hFFFFFFFE);

    do_op("smull_m1x2", 32'hFFFFFFFF, 32'd2, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0);
    do_op("smull_minsq", 32'h80000000, 32'h80000000, 1, 1, 0, 32'h40000000, 32'h0, 0, 0);
    do_op("smul_m3xm5", 32'hFFFFFFFD, 32'hFFFFFFFB, 1, 0, 0, 32'h0, 32'hF, 0, 0);
    do_op("smul_minx1", 32'h80000000, 32'd1, 1, 0, 0, 32'h0, 32'h80000000, 1, 0);
    do_op("umull_2p32", 32'h10000, 32'h10000, 0, 1, 0, 32'h1, 32'h0, 0, 0);
    do_op("umul_2p32", 32'h10000, 32'h10000, 0, 0, 0, 32'h0, 32'h0, 0, 1);
    do_op("zero_stray", 32'h0, 32'h1234, 0, 1, 5, 32'h0, 32'h0, 0, 1);

`ifdef MUL_ACCUM_EN
    acc_hi = 32'h0; acc_lo = 32'hFFFFFFFF; acc_en = 1'b1;
    do_op("umlal", 32'd3, 32'd4, 0, 1, 0, 32'h1, 32'hB, 0, 0);
    acc_en = 1'b0;
`endif

    do_op("umul_pre_rst", 32'd7, 32'd6, 0, 0, 0, 32'h0, 32'h2A, 0, 0);

    // reset in the middle of CALC aborts without a done pulse
    a = 32'd5; b = 32'd5; op_signed = 0; op_long = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("midrst_busy_before", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_state", o_dbg_state, IDLE);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_lo", result_lo, 0);
    check("midrst_hi", result_hi, 0);
    check("midrst_n", flag_n, 0);
    check("midrst_z", flag_z, 1);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);

    // start coincident with reset is discarded
    a = 32'd3; b = 32'd3; start = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    check("rststart_state", o_dbg_state, IDLE);
    check("rststart_busy", busy, 0);
    @(posedge clk); #1;
    check("rststart_state2", o_dbg_state, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
